// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux_reg: N valid/ready producer channels and one registered consumer side.
// master drives the producer inputs and the consumer ready; slave is the mux itself.
interface rr_mux_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        s;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_sel;

   modport master (
      output in_data, in_valid, mode, s, out_ready,
      input  in_ready, out_data, out_valid, out_sel
   );

   modport slave (
      input  in_data, in_valid, mode, s, out_ready,
      output in_ready, out_data, out_valid, out_sel
   );
endinterface

// File: rtl/rr_mux_reg.sv
// N:1 registered multiplexer with valid/ready on every channel.
// Channel choice is either an external select or round-robin arbitration.
module rr_mux_reg #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input logic      clk,
   input logic      rst_n,
   rr_mux_if.slave  bus
);

   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  gidx;
   logic              found;
   logic [WIDTH-1:0]  gdata;
   logic              free;
   logic [SEL_W-1:0]  ptr_nxt;

   logic [SEL_W-1:0]  rr_ptr;
   logic [WIDTH-1:0]  data_p1;
   logic [SEL_W-1:0]  sel_p1;
   logic              vld_p1;

   // Stage 0: grant selection and input data steering
   always_comb begin
      int idx;
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      if (!bus.mode) begin
         if (int'(bus.s) < NUM_IN && bus.in_valid[bus.s]) begin
            found = 1'b1;
            gidx  = bus.s;
         end
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && bus.in_valid[idx]) begin
               found = 1'b1;
               gidx  = SEL_W'(idx);
            end
         end
      end
      if (found) grant[gidx] = 1'b1;
   end

   always_comb begin
      gdata = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (SEL_W'(i) == gidx) gdata = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   // Load-while-drain: the register is free whenever the consumer takes the held word.
   assign free         = !vld_p1 || bus.out_ready;
   assign bus.in_ready = grant & {NUM_IN{free}};
   assign ptr_nxt      = (gidx == SEL_W'(NUM_IN-1)) ? '0 : gidx + 1'b1;

   // Stage 1: output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= '0;
         rr_ptr  <= '0;
      end else if (free) begin
         vld_p1 <= found;
         if (found) begin
            data_p1 <= gdata;
            sel_p1  <= gidx;
            if (bus.mode) rr_ptr <= ptr_nxt;
         end
      end
   end

   assign bus.out_data  = data_p1;
   assign bus.out_sel   = sel_p1;
   assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: an 8-input and a 5-input instance exercised side by side.
module tb_rr_mux_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_mux_if #(.WIDTH(16), .NUM_IN(8)) a ();
   rr_mux_if #(.WIDTH(16), .NUM_IN(5)) b ();

   rr_mux_reg #(.WIDTH(16), .NUM_IN(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(a));
   rr_mux_reg #(.WIDTH(16), .NUM_IN(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a.in_valid = '0; a.mode = 1'b0; a.s = '0; a.out_ready = 1'b1;
      b.in_valid = '0; b.mode = 1'b0; b.s = '0; b.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) a.in_data[i*16 +: 16] = 16'hA000 + 16'(i);
      for (int i = 0; i < 5; i++) b.in_data[i*16 +: 16] = 16'hB000 + 16'(i);
      #3;
      checks++;
      if (a.out_valid !== 1'b0 || a.out_data !== 16'h0 || a.out_sel !== 3'd0) begin
         errors++;
         $display("FAIL reset8: vld=%b data=%h sel=%0d expected 0/0000/0", a.out_valid, a.out_data, a.out_sel);
      end
      checks++;
      if (b.out_valid !== 1'b0 || b.out_data !== 16'h0 || b.out_sel !== 3'd0) begin
         errors++;
         $display("FAIL reset5: vld=%b data=%h sel=%0d expected 0/0000/0", b.out_valid, b.out_data, b.out_sel);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_direct();
      a.mode = 1'b0; a.in_valid = 8'hFF; a.out_ready = 1'b1;
      for (int s = 0; s < 8; s++) begin
         a.s = 3'(s);
         #1;
         checks++;
         if (a.in_ready !== (8'b1 << s)) begin
            errors++;
            $display("FAIL direct_ready s=%0d: got %b expected %b", s, a.in_ready, 8'b1 << s);
         end
         step();
         checks++;
         if (a.out_valid !== 1'b1 || a.out_data !== 16'hA000 + 16'(s) || a.out_sel !== 3'(s)) begin
            errors++;
            $display("FAIL direct_out s=%0d: vld=%b data=%h sel=%0d expected 1/%h/%0d",
                     s, a.out_valid, a.out_data, a.out_sel, 16'hA000 + 16'(s), s);
         end
      end
   endtask

   task automatic test_rr_fairness();
      int cnt [8];
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      a.mode = 1'b1; a.in_valid = 8'hFF; a.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         for (int i = 0; i < 8; i++) if (a.in_ready[i]) cnt[i]++;
         checks++;
         if (a.in_ready !== (8'b1 << (k % 8))) begin
            errors++;
            $display("FAIL rr_ready k=%0d: got %b expected %b", k, a.in_ready, 8'b1 << (k % 8));
         end
         step();
         checks++;
         if (a.out_sel !== 3'(k % 8) || a.out_data !== 16'hA000 + 16'(k % 8) || a.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_out k=%0d: sel=%0d data=%h expected %0d/%h", k, a.out_sel, a.out_data, k % 8,
                     16'hA000 + 16'(k % 8));
         end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cnt[i] != 2) begin
            errors++;
            $display("FAIL rr_count ch=%0d: got %0d expected 2", i, cnt[i]);
         end
      end
   endtask

   task automatic test_sparse_wrap();
      logic [2:0] exp8 [4];
      logic [2:0] exp5 [3];
      exp8[0] = 3'd2; exp8[1] = 3'd6; exp8[2] = 3'd2; exp8[3] = 3'd6;
      exp5[0] = 3'd4; exp5[1] = 3'd0; exp5[2] = 3'd4;
      // Park the 8-input pointer at 7 by granting channel 6 alone.
      a.mode = 1'b1; a.in_valid = 8'h40; a.out_ready = 1'b1;
      step();
      a.in_valid = 8'h44;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (a.out_sel !== exp8[k] || a.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sparse8 k=%0d: sel=%0d vld=%b expected %0d/1", k, a.out_sel, a.out_valid, exp8[k]);
         end
      end
      // Park the 5-input pointer at 4 by granting channel 3 alone.
      b.mode = 1'b1; b.in_valid = 5'b01000; b.out_ready = 1'b1;
      step();
      b.in_valid = 5'b10001;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (b.out_sel !== exp5[k] || b.out_data !== 16'hB000 + 16'(exp5[k])) begin
            errors++;
            $display("FAIL wrap5 k=%0d: sel=%0d data=%h expected %0d", k, b.out_sel, b.out_data, exp5[k]);
         end
      end
      b.in_valid = '0;
   endtask

   task automatic test_backpressure();
      a.mode = 1'b0; a.s = 3'd1; a.in_valid = 8'hFF; a.out_ready = 1'b1;
      step();
      a.out_ready = 1'b0; a.s = 3'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (a.in_ready !== 8'h00) begin
            errors++;
            $display("FAIL bp_ready k=%0d: got %b expected 00000000", k, a.in_ready);
         end
         step();
         checks++;
         if (a.out_valid !== 1'b1 || a.out_data !== 16'hA001 || a.out_sel !== 3'd1) begin
            errors++;
            $display("FAIL bp_hold k=%0d: vld=%b data=%h sel=%0d expected 1/a001/1", k, a.out_valid, a.out_data, a.out_sel);
         end
      end
      a.out_ready = 1'b1;
      #1;
      checks++;
      if (a.in_ready !== 8'h04) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 00000100", a.in_ready);
      end
      step();
      checks++;
      if (a.out_valid !== 1'b1 || a.out_data !== 16'hA002 || a.out_sel !== 3'd2) begin
         errors++;
         $display("FAIL bp_release_out: vld=%b data=%h sel=%0d expected 1/a002/2", a.out_valid, a.out_data, a.out_sel);
      end
   endtask

   task automatic test_out_of_range();
      b.mode = 1'b0; b.s = 3'd3; b.in_valid = 5'b11111; b.out_ready = 1'b1;
      step();
      checks++;
      if (b.out_valid !== 1'b1 || b.out_data !== 16'hB003) begin
         errors++;
         $display("FAIL oor_load: vld=%b data=%h expected 1/b003", b.out_valid, b.out_data);
      end
      b.s = 3'd6;
      #1;
      checks++;
      if (b.in_ready !== 5'b00000) begin
         errors++;
         $display("FAIL oor_ready: got %b expected 00000", b.in_ready);
      end
      step();
      checks++;
      if (b.out_valid !== 1'b0 || b.out_data !== 16'hB003 || b.out_sel !== 3'd3) begin
         errors++;
         $display("FAIL oor_drain: vld=%b data=%h sel=%0d expected 0/b003/3", b.out_valid, b.out_data, b.out_sel);
      end
      b.s = 3'd5;
      #1;
      checks++;
      if (b.in_ready !== 5'b00000) begin
         errors++;
         $display("FAIL oor_ready5: got %b expected 00000", b.in_ready);
      end
      b.in_valid = '0;
   endtask

   task automatic test_reset_midstream();
      a.mode = 1'b0; a.s = 3'd5; a.in_valid = 8'hFF; a.out_ready = 1'b1;
      step();
      a.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a.out_valid !== 1'b0 || a.out_data !== 16'h0 || a.out_sel !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: vld=%b data=%h sel=%0d expected 0/0000/0", a.out_valid, a.out_data, a.out_sel);
      end
      rst_n = 1'b1;
      a.mode = 1'b1; a.out_ready = 1'b1;
      #1;
      checks++;
      if (a.in_ready !== 8'h01) begin
         errors++;
         $display("FAIL post_reset_ready: got %b expected 00000001", a.in_ready);
      end
      step();
      checks++;
      if (a.out_sel !== 3'd0 || a.out_valid !== 1'b1 || a.out_data !== 16'hA000) begin
         errors++;
         $display("FAIL post_reset_grant: sel=%0d vld=%b data=%h expected 0/1/a000", a.out_sel, a.out_valid, a.out_data);
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_rr_fairness();
      test_sparse_wrap();
      test_backpressure();
      test_out_of_range();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes: direct (external select, as a classic N:1 mux) and round-robin arbitration across requesting inputs.
- Sits in the RISC-V datapath/interconnect wherever several producers share one consumer (writeback source select, shared memory port), adding a pipeline register and fairness.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 8, number of input channels (>=2, need not be a power of two).
- SEL_W, $clog2(NUM_IN), width of select and grant-index fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  channel i has data.
- in_ready  output  NUM_IN  channel i transfer accepted this cycle.
- mode  input  1  0 = direct select, 1 = round-robin.
- s  input  SEL_W  channel select in direct mode; ignored in round-robin mode.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. Deassertion is synchronised externally; the block takes no action on the first edge beyond normal operation.
- Output register free when out_valid==0 or out_ready==1 (load-while-drain allowed).
- Grant (combinational, one-hot or none):
  - mode=0: grant channel s iff s<NUM_IN and in_valid[s]. If s>=NUM_IN, there is no grant.
  - mode=1: grant the first i with in_valid[i], scanning from rr_ptr upward with wrap modulo NUM_IN.
- in_ready[i] = grant[i] & free. At most one bit is set. in_ready never depends on in_valid of other channels in mode 0.
- Transfer occurs when in_valid[g] & in_ready[g]. On the next edge: out_data=channel g data, out_sel=g, out_valid=1.
- If free but no grant: out_valid goes to 0 on the next edge; out_data and out_sel hold their previous values.
- If not free: all registers hold; in_ready=0.
- Latency: exactly one clock from accepted input to out_valid. Throughput is one word per cycle when out_ready is held high.
- rr_ptr updates only on a transfer in mode 1: rr_ptr = (g+1) mod NUM_IN, wrapping NUM_IN-1 to 0. Mode-0 transfers leave rr_ptr unchanged.
- A mode or s change takes effect on the same-cycle grant evaluation. The word already held in the output register is unaffected.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel remain constant.
- Reset mid-transfer drops the held word. No partial state survives.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately, without waiting for clk. The first round-robin grant after release goes to channel 0 if it is valid.
- Direct mode, WIDTH=16, NUM_IN=8, mode=0, out_ready=1: sweep s=0..7 with in_data[i]=16'hA000+i and all valid -> each following cycle out_data=16'hA000+s, out_sel=s, and only in_ready[s]=1.
- Round-robin fairness: mode=1, all 8 valid, out_ready=1 for 16 cycles -> out_sel sequence 0,1,...,7,0,...,7. Each in_ready bit is high exactly twice.
- Sparse and wrap: mode=1, only channels 2 and 6 valid, rr_ptr=7 -> grant order 2,6,2,6. Then NUM_IN=5 build with channels 4 and 0 valid -> 4,0 with correct wrap.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new inputs valid -> all in_ready=0 and out_data/out_sel stable. Release out_ready -> the held word drains and the next word loads on the same edge with no bubble.
- Out-of-range select: NUM_IN=5, mode=0, s=6, all valid -> in_ready=0 and out_valid falls to 0 after the current word drains.
